// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - register file port bundle: read, write, reserve, debug and scoreboard signals
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              busy1;
  logic              busy2;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              resvEn;
  logic [ADDR_W-1:0] resvAddr;
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgData;
  logic [ADDR_W:0]   pendCount;

  modport master (
    output rs, rt, wrEn, wrAddr, wrData, resvEn, resvAddr, dbgAddr,
    input  readData1, readData2, busy1, busy2, dbgData, pendCount
  );

  modport slave (
    input  rs, rt, wrEn, wrAddr, wrData, resvEn, resvAddr, dbgAddr,
    output readData1, readData2, busy1, busy2, dbgData, pendCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write bypass, optional zero register and busy scoreboard
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   pend_q;
  logic [ADDR_W:0]   pend_next;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZR && (a == '0);
  endfunction

  // A result retiring this cycle is forwarded straight from the write port.
  function automatic logic [DATA_W-1:0] rd_value(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (is_zero(a))
      return '0;
    else if (we && (wa == a))
      return wd;
    else
      return stored;
  endfunction

  function automatic logic busy_value(
    input logic [ADDR_W-1:0] a,
    input logic              stored,
    input logic              we,
    input logic [ADDR_W-1:0] wa
  );
    return !is_zero(a) && stored && !(we && (wa == a));
  endfunction

  assign bus.readData1 = rd_value(bus.rs, mem[bus.rs], bus.wrEn, bus.wrAddr, bus.wrData);
  assign bus.readData2 = rd_value(bus.rt, mem[bus.rt], bus.wrEn, bus.wrAddr, bus.wrData);
  assign bus.dbgData   = rd_value(bus.dbgAddr, mem[bus.dbgAddr], bus.wrEn, bus.wrAddr, bus.wrData);
  assign bus.busy1     = busy_value(bus.rs, busy_q[bus.rs], bus.wrEn, bus.wrAddr);
  assign bus.busy2     = busy_value(bus.rt, busy_q[bus.rt], bus.wrEn, bus.wrAddr);
  assign bus.pendCount = pend_q;

  // Set is applied after clear so a same-cycle reserve of a retiring register keeps it busy.
  always_comb begin
    busy_next = busy_q;
    if (bus.wrEn && !is_zero(bus.wrAddr))
      busy_next[bus.wrAddr] = 1'b0;
    if (bus.resvEn && !is_zero(bus.resvAddr))
      busy_next[bus.resvAddr] = 1'b1;
    if (ZR)
      busy_next[0] = 1'b0;
  end

  always_comb begin
    pend_next = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_next = pend_next + (ADDR_W+1)'(busy_next[i]);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      if (bus.wrEn && !is_zero(bus.wrAddr))
        mem[bus.wrAddr] <= bus.wrData;
      busy_q <= busy_next;
      pend_q <= pend_next;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic CLK = 1'b0;
  logic Reset;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m [32];
  logic        b [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m[a];
  endfunction

  function automatic logic [31:0] m_busy(input logic [4:0] a, input logic we, input logic [4:0] wa);
    if (a == 5'd0) return 32'd0;
    return {31'd0, b[a] && !(we && wa == a)};
  endfunction

  function automatic logic [31:0] m_pend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(b[i]);
    return 32'(n);
  endfunction

  task automatic cyc(input logic rst_i, input logic [4:0] rs_i, input logic [4:0] rt_i,
                     input logic [4:0] dbg_i, input logic we_i, input logic [4:0] wa_i,
                     input logic [31:0] wd_i, input logic re_i, input logic [4:0] ra_i);
    exp_t e;
    Reset        = rst_i;
    bus.rs       = rs_i;
    bus.rt       = rt_i;
    bus.dbgAddr  = dbg_i;
    bus.wrEn     = we_i;
    bus.wrAddr   = wa_i;
    bus.wrData   = wd_i;
    bus.resvEn   = re_i;
    bus.resvAddr = ra_i;
    e.sel = 0; e.exp = m_rd(rs_i, we_i, wa_i, wd_i);  q.push_back(e);
    e.sel = 1; e.exp = m_rd(rt_i, we_i, wa_i, wd_i);  q.push_back(e);
    e.sel = 2; e.exp = m_rd(dbg_i, we_i, wa_i, wd_i); q.push_back(e);
    e.sel = 3; e.exp = m_busy(rs_i, we_i, wa_i);      q.push_back(e);
    e.sel = 4; e.exp = m_busy(rt_i, we_i, wa_i);      q.push_back(e);
    e.sel = 5; e.exp = m_pend();                      q.push_back(e);
    @(negedge CLK);
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0: check("readData1", bus.readData1, e.exp);
        1: check("readData2", bus.readData2, e.exp);
        2: check("dbgData", bus.dbgData, e.exp);
        3: check("busy1", {31'd0, bus.busy1}, e.exp);
        4: check("busy2", {31'd0, bus.busy2}, e.exp);
        default: check("pendCount", {26'd0, bus.pendCount}, e.exp);
      endcase
    end
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m[i] = 32'd0;
        b[i] = 1'b0;
      end
    end else begin
      if (we_i && wa_i != 5'd0) begin
        m[wa_i] = wd_i;
        b[wa_i] = 1'b0;
      end
      if (re_i && ra_i != 5'd0) b[ra_i] = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    Reset = 1'b1;
    bus.rs = '0; bus.rt = '0; bus.dbgAddr = '0;
    bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.resvEn = 1'b0; bus.resvAddr = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = 32'd0;
      b[i] = 1'b0;
    end
    @(posedge CLK);
    #1;

    for (int i = 0; i < 32; i++)
      cyc(0, 5'(i), 5'(31 - i), 5'(i), 0, 0, 0, 0, 0);

    cyc(0, 5, 0, 5, 1, 5, 32'hDEADBEEF, 0, 0);
    cyc(0, 5, 5, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 5, 0, 1, 0, 32'h1234, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 7, 7, 0, 0, 0, 1, 7);
    cyc(0, 0, 7, 7, 1, 7, 32'hA5, 0, 0);
    cyc(0, 7, 7, 7, 0, 0, 0, 0, 0);

    cyc(0, 9, 9, 9, 0, 0, 0, 1, 9);
    cyc(0, 9, 9, 9, 1, 9, 32'h99, 1, 9);
    cyc(0, 9, 9, 9, 1, 9, 32'h9A, 0, 0);

    cyc(0, 1, 2, 3, 0, 0, 0, 1, 1);
    cyc(0, 1, 2, 3, 0, 0, 0, 1, 2);
    cyc(0, 1, 2, 3, 0, 0, 0, 1, 3);
    cyc(1, 1, 2, 3, 1, 2, 32'h2222, 0, 0);
    cyc(0, 1, 2, 3, 0, 0, 0, 0, 0);
    cyc(0, 2, 7, 5, 1, 2, 32'h55, 0, 0);
    cyc(0, 2, 1, 3, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 63) == 0), raddr(), raddr(), raddr(),
          ($urandom_range(0, 2) != 0), raddr(), $urandom,
          ($urandom_range(0, 1) != 0), raddr());

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
